exhaustive_vector_sweeper: RTL

- Synthesizable, parametrised successor to the lab's exhaustive 3-input sweep bench.
- Walks every input vector of an IN_W-bit combinational DUT and holds each vector for a programmable settle time.
- Samples the OUT_W-bit DUT response, flags and counts all-zero responses, and reports completion.
- Sits between the board controls (start button/switch) and any combinational lab block, so sweeps can run on hardware, not only in simulation.

---
 rtl/exhaustive_vector_sweeper.sv | 138 +++++++++++++
 1 files changed

// File: rtl/exhaustive_vector_sweeper.sv
// Walks every IN_W-bit vector into a combinational DUT, holds each for SETTLE+1 cycles, samples and counts all-zero responses.
// Optional 16-bit MISR signature output o_sig when SWEEP_MISR_EN is defined.
module exhaustive_vector_sweeper #(
  parameter int IN_W   = 3,
  parameter int OUT_W  = 2,
  parameter int SETTLE = 19
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [OUT_W-1:0] i_dut_out,
  output logic [IN_W-1:0]  o_dut_in,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_sample_valid,
  output logic             o_zero_hit,
  output logic [IN_W:0]    o_zero_count
`ifdef SWEEP_MISR_EN
  ,
  output logic [15:0]      o_sig
`endif
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [IN_W-1:0]  VEC_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [IN_W-1:0]   r_dut_in;
  logic              r_busy;
  logic              r_done;
  logic              r_sample_valid;
  logic              r_zero_hit;
  logic [IN_W:0]     r_zero_count;
  logic              w_zero;
  logic              w_start_ok;

  assign w_zero     = (i_dut_out == '0);
  assign w_start_ok = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // The counter is cleared on the way into SAMPLE so it never needs to hold SETTLE itself.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_dut_in       <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_sample_valid <= 1'b0;
      r_zero_hit     <= 1'b0;
      r_zero_count   <= '0;
    end else begin
      r_sample_valid <= 1'b0;
      r_zero_hit     <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_state      <= S_SETTLE;
            r_dut_in     <= '0;
            r_cnt        <= '0;
            r_zero_count <= '0;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
          end
        end
        S_SETTLE: begin
          if (r_cnt == CNT_LAST) begin
            r_state <= S_SAMPLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_SAMPLE: begin
          r_sample_valid <= 1'b1;
          r_zero_hit     <= w_zero;
          if (w_zero) begin
            r_zero_count <= r_zero_count + 1'b1;
          end
          if (r_dut_in == VEC_LAST) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_dut_in <= r_dut_in + 1'b1;
            r_cnt    <= '0;
            r_state  <= S_SETTLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_dut_in       = r_dut_in;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_sample_valid = r_sample_valid;
  assign o_zero_hit     = r_zero_hit;
  assign o_zero_count   = r_zero_count;

`ifdef SWEEP_MISR_EN
  logic [15:0] r_sig;
  logic [15:0] w_sig_next;

  // CRC-16/CCITT style shift with the response folded into the low bits.
  assign w_sig_next = ({r_sig[14:0], 1'b0} ^ (r_sig[15] ? 16'h1021 : 16'h0000))
                      ^ 16'(i_dut_out);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sig <= '0;
    end else if (w_start_ok) begin
      r_sig <= '0;
    end else if (r_state == S_SAMPLE) begin
      r_sig <= w_sig_next;
    end
  end

  assign o_sig = r_sig;
`else
  logic w_unused;
  assign w_unused = w_start_ok;
`endif

endmodule
